// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the boot loader.
//   rx_valid / rx_data / rx_ready : byte source handshake (transfer on valid && ready)
//   we / waddr / wdata            : single-cycle word write strobe, byte address, data
// Modport master is the loader side: it consumes the byte stream and drives the write port.
// Modport slave is the environment side: byte source plus memory.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output we,
        output waddr,
        output wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  we,
        input  waddr,
        input  wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// Parses frames of the form SYNC, LEN_lo, LEN_hi, 4*N payload bytes, CSUM (XOR of payload),
// assembles little-endian words and writes them to instruction memory, then releases the
// core from reset once the checksum matches.
//   clk          : system clock, rising edge
//   rst          : synchronous active-high reset
//   bus          : byte stream in + memory write port (imem_loader_if.master)
//   core_rst     : reset to the core, high until a frame loads with a good checksum
//   done         : sticky, load complete and checksum good
//   err          : sticky, frame error (oversize length or checksum mismatch)
//   words_loaded : number of words written in this load
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_loader_if.master         bus,
    output logic                  core_rst,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        StSync,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam logic [ADDR_WIDTH:0] WordInc = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [31:0]         MaxWords = 32'd1 << ADDR_WIDTH;

    state_e      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] shift;     // first three bytes of the word being assembled, oldest at [7:0]
    logic [7:0]  csum;

    logic        accept;
    logic [15:0] len_next;
    logic        oversize;
    logic        last_word;
    logic [31:0] word_addr;

    // Ready depends on state (and reset) only, never on rx_valid.
    assign bus.rx_ready = ~rst & (state != StDone) & (state != StErr);
    assign accept       = bus.rx_valid & bus.rx_ready;

    assign len_next  = {bus.rx_data, len_lo};
    assign oversize  = {16'd0, len_next} > MaxWords;
    // words_loaded doubles as the index of the word currently being assembled.
    assign last_word = (32'(words_loaded) + 32'd1) == {16'd0, len};
    assign word_addr = BASE_ADDR + (32'(words_loaded) << 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StSync;
            bus.we       <= 1'b0;
            bus.waddr    <= 32'd0;
            bus.wdata    <= 32'd0;
            core_rst     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            byte_idx     <= 2'd0;
            shift        <= 24'd0;
            csum         <= 8'd0;
        end else begin
            bus.we <= 1'b0;
            if (accept) begin
                case (state)
                    StSync: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            state <= StLen0;
                        end
                    end
                    StLen0: begin
                        len_lo <= bus.rx_data;
                        state  <= StLen1;
                    end
                    StLen1: begin
                        len <= len_next;
                        if (oversize) begin
                            state <= StErr;
                            err   <= 1'b1;
                        end else if (len_next == 16'd0) begin
                            state <= StCsum;
                        end else begin
                            state <= StData;
                        end
                    end
                    StData: begin
                        csum     <= csum ^ bus.rx_data;
                        shift    <= {bus.rx_data, shift[23:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            // Write strobe and count become visible together next cycle,
                            // overlapping acceptance of the next word's first byte.
                            bus.wdata    <= {bus.rx_data, shift};
                            bus.waddr    <= word_addr;
                            bus.we       <= 1'b1;
                            words_loaded <= words_loaded + WordInc;
                            if (last_word) begin
                                state <= StCsum;
                            end
                        end
                    end
                    StCsum: begin
                        if (bus.rx_data == csum) begin
                            state    <= StDone;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= StErr;
                            err   <= 1'b1;
                        end
                    end
                    default: begin
                        // StDone / StErr are terminal and never accept.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed frames against a frame-level reference model.
// The model re-parses every byte accepted since the last reset and derives the expected
// words written, done/err status and the expected write on each cycle.
module tb_imem_loader;

    localparam int unsigned AW   = 10;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_rst;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    imem_loader_if bus ();

    imem_loader #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .SYNC_BYTE  (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .core_rst     (core_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  hist[$];          // bytes accepted since the last reset
    bit          chk_en = 1'b0;
    int          wr_total = 0;     // we pulses seen by the compare process
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_wdata = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level parse of everything accepted so far.
    function automatic void model_eval(output int words, output bit m_done, output bit m_err,
                                       output logic [31:0] lw);
        int i = 0;
        int n;
        int pay;
        int p;
        logic [7:0] x = 8'd0;
        words  = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
        lw     = 32'd0;
        while (i < hist.size() && hist[i] != SYNC) i++;
        i++;
        if (i + 2 > hist.size()) return;
        n = int'(hist[i]) | (int'(hist[i+1]) << 8);
        i += 2;
        if (n > (1 << AW)) begin
            m_err = 1'b1;
            return;
        end
        pay = hist.size() - i;
        if (pay > 4 * n) pay = 4 * n;
        for (int k = 0; k < pay; k++) x ^= hist[i+k];
        words = pay / 4;
        if (words > 0) begin
            p  = i + 4 * (words - 1);
            lw = {hist[p+3], hist[p+2], hist[p+1], hist[p]};
        end
        if (hist.size() > i + 4 * n) begin
            if (hist[i + 4*n] == x) m_done = 1'b1;
            else m_err = 1'b1;
        end
    endfunction

    // Monitor: record accepted bytes at the active edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                hist.delete();
                chk_en = 1'b1;
            end else if (bus.rx_valid && bus.rx_ready) begin
                hist.push_back(bus.rx_data);
            end
        end
    end

    // Compare process: every cycle, on the falling edge.
    initial begin
        int          words;
        int          prev_words = 0;
        bit          m_done;
        bit          m_err;
        logic [31:0] lw;
        bit          we_exp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                model_eval(words, m_done, m_err, lw);
                check("rx_ready", 32'(bus.rx_ready), 32'(!rst && !m_done && !m_err));
                check("done", 32'(done), 32'(m_done));
                check("err", 32'(err), 32'(m_err));
                check("core_rst", 32'(core_rst), 32'(!m_done));
                check("words_loaded", 32'(words_loaded), 32'(words));
                we_exp = words > prev_words;
                check("we", 32'(bus.we), 32'(we_exp));
                if (we_exp) begin
                    check("waddr", bus.waddr, BASE + 32'(4 * (words - 1)));
                    check("wdata", bus.wdata, lw);
                end
                if (bus.we === 1'b1) begin
                    wr_total++;
                    last_waddr = bus.waddr;
                    last_wdata = bus.wdata;
                end
                prev_words = words;
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int c = 0; c < 40 && !acc; c++) begin
            @(posedge clk);
            acc = bus.rx_ready;
            #1;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_waddr", bus.waddr, 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        rst = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] q[$], input int gap);
        foreach (q[k]) send(q[k], gap);
    endtask

    initial begin
        int         w0;
        logic [7:0] q[$];
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        repeat (2) @(posedge clk);

        // Single word, back to back.
        do_reset();
        w0 = wr_total;
        q = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
        send_list(q, 0);
        check("s1_done", 32'(done), 32'd1);
        check("s1_core_rst", 32'(core_rst), 32'd0);
        check("s1_words", 32'(words_loaded), 32'd1);
        check("s1_writes", 32'(wr_total - w0), 32'd1);
        check("s1_waddr", last_waddr, 32'h0);
        check("s1_wdata", last_wdata, 32'h0050_0093);
        check("s1_rx_ready", 32'(bus.rx_ready), 32'd0);

        // Garbage before sync, gaps between bytes.
        do_reset();
        w0 = wr_total;
        q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
        send_list(q, 3);
        check("s2_done", 32'(done), 32'd1);
        check("s2_writes", 32'(wr_total - w0), 32'd2);
        check("s2_waddr", last_waddr, 32'h4);
        check("s2_wdata", last_wdata, 32'h0000_006F);

        // Bad checksum.
        do_reset();
        w0 = wr_total;
        q = '{8'hA5, 8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
        send_list(q, 0);
        check("s3_err", 32'(err), 32'd1);
        check("s3_done", 32'(done), 32'd0);
        check("s3_core_rst", 32'(core_rst), 32'd1);
        check("s3_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("s3_writes", 32'(wr_total - w0), 32'd1);

        // Oversize length (1025).
        do_reset();
        w0 = wr_total;
        q = '{8'hA5, 8'h01, 8'h04};
        send_list(q, 0);
        check("s4_err", 32'(err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("s4_writes", 32'(wr_total - w0), 32'd0);

        // Zero length.
        do_reset();
        w0 = wr_total;
        q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_list(q, 0);
        check("s5_done", 32'(done), 32'd1);
        check("s5_words", 32'(words_loaded), 32'd0);
        check("s5_writes", 32'(wr_total - w0), 32'd0);

        // Reset mid-frame, then a fresh frame from BASE.
        do_reset();
        q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
        send_list(q, 0);
        do_reset();
        w0 = wr_total;
        q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_list(q, 0);
        check("s6_done", 32'(done), 32'd1);
        check("s6_writes", 32'(wr_total - w0), 32'd1);
        check("s6_waddr", last_waddr, BASE);
        check("s6_wdata", last_wdata, 32'h1234_5678);

        // Largest legal frame: 2^AW words.
        do_reset();
        w0 = wr_total;
        begin
            logic [7:0] x = 8'd0;
            logic [7:0] b;
            send(8'hA5, 0);
            send(8'h00, 0);
            send(8'h04, 0);
            for (int k = 0; k < 4 * (1 << AW); k++) begin
                b = 8'($urandom);
                x ^= b;
                send(b, 0);
            end
            send(x, 0);
        end
        check("big_done", 32'(done), 32'd1);
        check("big_words", 32'(words_loaded), 32'(1 << AW));
        check("big_writes", 32'(wr_total - w0), 32'(1 << AW));
        check("big_waddr", last_waddr, BASE + 32'(4 * ((1 << AW) - 1)));

        // Randomized frames, some cut short by a reset.
        for (int f = 0; f < 40; f++) begin
            int         n;
            int         cut;
            bit         good;
            bit         big;
            logic [7:0] x;
            logic [7:0] g;
            do_reset();
            w0 = wr_total;
            q.delete();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                q.push_back(g);
            end
            big  = ($urandom_range(0, 9) == 0);
            n    = big ? 1025 + int'($urandom_range(0, 60000)) : int'($urandom_range(0, 6));
            good = ($urandom_range(0, 3) != 0);
            q.push_back(SYNC);
            q.push_back(8'(n));
            q.push_back(8'(n >> 8));
            if (!big) begin
                x = 8'd0;
                for (int k = 0; k < 4 * n; k++) begin
                    g = 8'($urandom);
                    x ^= g;
                    q.push_back(g);
                end
                q.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
            end
            cut = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, q.size() - 1)) : q.size();
            for (int k = 0; k < cut; k++) begin
                send(q[k], ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            end
            bus.rx_valid = 1'b0;
            @(posedge clk);
            #1;
            if (cut == q.size()) begin
                if (big) begin
                    check("rnd_err_big", 32'(err), 32'd1);
                    check("rnd_writes_big", 32'(wr_total - w0), 32'd0);
                end else begin
                    check("rnd_done", 32'(done), 32'(good));
                    check("rnd_err", 32'(err), 32'(!good));
                    check("rnd_writes", 32'(wr_total - w0), 32'(n));
                end
            end
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
